// File: rtl/jk_excitation_driver_if.sv
// Request and JK-bank bus between a requester/bank model and jk_excitation_driver.
// No latency of its own; it only carries wires.
// The requester holds start until it sees ready; the driver raises ready only in IDLE.
interface jk_excitation_driver_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] q_fb;
    logic             ready;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] expected;

    // Driver side: takes the request and bank feedback, produces J/K and status.
    modport slave (
        input  start,
        input  target,
        input  q_fb,
        output ready,
        output j,
        output k,
        output busy,
        output done,
        output err,
        output expected
    );

    // Requester side, which also owns the JK bank feedback.
    modport master (
        output start,
        output target,
        output q_fb,
        input  ready,
        input  j,
        input  k,
        input  busy,
        input  done,
        input  err,
        input  expected
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// Steps an external JK flop bank from its value up to a target, one increment per step, checking feedback.
// Latency: done is high 2*S+1 cycles after the accepting edge (S = (target - q_fb) mod 2^WIDTH).
// Backpressure: start is taken only while ready=1 (IDLE); it is ignored otherwise, ERR is left only by reset.
// Build option: define JK_TOGGLE_EN to drive changing bits with j=k=1 (toggle) instead of set/reset.
module jk_excitation_driver #(
    parameter int WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    jk_excitation_driver_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] target_q,   target_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [WIDTH-1:0] j_q,        j_d;
    logic [WIDTH-1:0] k_q,        k_d;
    logic             ready_q,    ready_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             err_q,      err_d;

    // J input needed to move each bit from its present value to its next value.
    function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] q_now,
                                               input logic [WIDTH-1:0] q_next);
`ifdef JK_TOGGLE_EN
        return q_now ^ q_next;
`else
        return ~q_now & q_next;
`endif
    endfunction

    // K input needed to move each bit from its present value to its next value.
    function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] q_now,
                                               input logic [WIDTH-1:0] q_next);
`ifdef JK_TOGGLE_EN
        return q_now ^ q_next;
`else
        return q_now & ~q_next;
`endif
    endfunction

    // Next-state and next-output computation; outputs follow the state being entered.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        expected_d = expected_q;
        j_d        = '0;
        k_d        = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    target_d = bus.target;
                    if (bus.q_fb == bus.target) begin
                        // Already there: report completion without issuing a step.
                        state_d = S_DONE;
                    end else begin
                        expected_d = bus.q_fb + WIDTH'(1);
                        state_d    = S_DRIVE;
                    end
                end
            end
            S_DRIVE: begin
                // The bank captures j/k on the edge leaving this state.
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (bus.q_fb != expected_q) begin
                    // Keep expected_q so the failing step stays visible.
                    state_d = S_ERR;
                end else if (expected_q == target_q) begin
                    state_d = S_DONE;
                end else begin
                    expected_d = expected_q + WIDTH'(1);
                    state_d    = S_DRIVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Excitation is only presented while in DRIVE, from the live feedback and the step goal.
        if (state_d == S_DRIVE) begin
            j_d = exc_j(bus.q_fb, expected_d);
            k_d = exc_k(bus.q_fb, expected_d);
        end

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_DRIVE) || (state_d == S_CHECK);
        done_d  = (state_d == S_DONE);
        err_d   = err_q || (state_d == S_ERR);
    end

    // State and registered outputs; reset abandons any step in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            expected_q <= '0;
            j_q        <= '0;
            k_q        <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            expected_q <= expected_d;
            j_q        <= j_d;
            k_q        <= k_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.j        = j_q;
    assign bus.k        = k_q;
    assign bus.expected = expected_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver with a behavioural 4-bit JK bank closing the q_fb loop.
// Inputs change and outputs are sampled on the falling edge; cyc counts edges since acceptance.
// A stuck-at mask on the bank model provokes the feedback error path.
module tb_jk_excitation_driver;

    localparam int W = 4;

    logic         clock;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] stuck;
    logic [W-1:0] bank;
    int           cyc;
    int           checks;
    int           failures;
    bit           jk11_seen;

    jk_excitation_driver_if #(.WIDTH(W)) bus ();

    jk_excitation_driver #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.q_fb = bank;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural JK bank: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits.
    always @(posedge clock) begin
        if (load) bank <= load_val & ~stuck;
        else      bank <= ((bus.j & ~bank) | (~bus.k & bank)) & ~stuck;
    end

    // Watch for j=k=1 on any bit.
    always @(negedge clock) begin
        if ((bus.j & bus.k) != '0) jk11_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic load_bank(input logic [W-1:0] v);
        load     = 1'b1;
        load_val = v;
        tick();
        load     = 1'b0;
    endtask

    task automatic issue(input logic [W-1:0] t);
        bus.start  = 1'b1;
        bus.target = t;
        cyc        = 0;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [31:0] done_cyc();
        return (bus.done === 1'b1) ? 32'(cyc) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        checks     = 0;
        failures   = 0;
        jk11_seen  = 1'b0;
        cyc        = 0;
        reset      = 1'b1;
        load       = 1'b0;
        load_val   = '0;
        stuck      = '0;
        bank       = '0;
        bus.start  = 1'b0;
        bus.target = '0;
        @(negedge clock);
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_ready",    bus.ready,    1);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_done",     bus.done,     0);
        chk("rst_err",      bus.err,      0);
        chk("rst_j",        bus.j,        0);
        chk("rst_k",        bus.k,        0);
        chk("rst_expected", bus.expected, 0);

        // 3 -> 6: three steps
        load_bank(4'd3);
        issue(4'd6);
        chk("t1_c1_j",     bus.j,        4'b0100);
        chk("t1_c1_k",     bus.k,        4'b0011);
        chk("t1_c1_exp",   bus.expected, 4);
        chk("t1_c1_busy",  bus.busy,     1);
        chk("t1_c1_ready", bus.ready,    0);
        tick();
        chk("t1_c2_j",     bus.j,        0);
        chk("t1_c2_bank",  bank,         4);
        tick();
        chk("t1_c3_exp",   bus.expected, 5);
        tick();
        tick();
        chk("t1_c5_exp",   bus.expected, 6);
        chk("t1_c5_j",     bus.j,        4'b0010);
        chk("t1_c5_k",     bus.k,        4'b0001);
        wait_done(20);
        chk("t1_done_cyc", done_cyc(),   7);
        chk("t1_err",      bus.err,      0);
        chk("t1_bank",     bank,         6);
        tick();
        chk("t1_ready_after", bus.ready, 1);
        chk("t1_done_pulse",  bus.done,  0);

        // 5 -> 5: no step
        load_bank(4'd5);
        issue(4'd5);
        chk("t2_done_c1", bus.done,  1);
        chk("t2_j",       bus.j,     0);
        chk("t2_k",       bus.k,     0);
        chk("t2_busy",    bus.busy,  0);
        chk("t2_ready",   bus.ready, 0);
        tick();
        chk("t2_ready_after", bus.ready, 1);
        chk("t2_done_pulse",  bus.done,  0);
        chk("t2_bank",        bank,      5);

        // 14 -> 1 through wrap-around
        load_bank(4'd14);
        issue(4'd1);
        chk("t3_c1_exp", bus.expected, 15);
        chk("t3_c1_j",   bus.j,        4'b0001);
        tick();
        tick();
        chk("t3_c3_exp", bus.expected, 0);
        chk("t3_c3_k",   bus.k,        4'b1111);
        chk("t3_c3_j",   bus.j,        4'b0000);
        wait_done(20);
        chk("t3_done_cyc", done_cyc(), 7);
        chk("t3_bank",     bank,       1);
        tick();

        // Bit0 stuck at 0: first check fails
        stuck = 4'b0001;
        load_bank(4'd0);
        issue(4'd2);
        chk("t4_c1_exp", bus.expected, 1);
        tick();
        tick();
        chk("t4_err",       bus.err,      1);
        chk("t4_exp_hold",  bus.expected, 1);
        chk("t4_ready",     bus.ready,    0);
        chk("t4_busy",      bus.busy,     0);
        bus.start  = 1'b1;
        bus.target = 4'd0;
        tick();
        tick();
        bus.start  = 1'b0;
        chk("t4_err_sticky", bus.err,   1);
        chk("t4_ignore_rdy", bus.ready, 0);
        chk("t4_ignore_dn",  bus.done,  0);
        chk("t4_ignore_j",   bus.j,     0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stuck = '0;
        chk("t4_rst_err",   bus.err,      0);
        chk("t4_rst_ready", bus.ready,    1);
        chk("t4_rst_exp",   bus.expected, 0);

        // Reset during the third DRIVE, then resume
        load_bank(4'd0);
        issue(4'd9);
        tick();
        tick();
        tick();
        tick();
        chk("t5_c5_busy", bus.busy,     1);
        chk("t5_c5_exp",  bus.expected, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_j",     bus.j,     0);
        chk("t5_rst_k",     bus.k,     0);
        chk("t5_rst_busy",  bus.busy,  0);
        chk("t5_rst_ready", bus.ready, 1);
        chk("t5_rst_done",  bus.done,  0);
        tick();
        tick();
        chk("t5_no_done", bus.done, 0);
        chk("t5_bank",    bank,     3);
        issue(4'd9);
        wait_done(40);
        chk("t5_done_cyc", done_cyc(), 13);
        chk("t5_bank_end", bank,       9);
        chk("t5_err",      bus.err,    0);
        tick();

`ifdef JK_TOGGLE_EN
        // Toggle encoding: 3 -> 4 flips bits 2..0
        load_bank(4'd3);
        issue(4'd4);
        chk("t6_j", bus.j, 4'b0111);
        chk("t6_k", bus.k, 4'b0111);
        wait_done(20);
        chk("t6_done_cyc", done_cyc(), 3);
        chk("t6_bank",     bank,       4);
        tick();
`else
        chk("no_jk11", 32'(jk11_seen), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Controller for the other end of a JK flip-flop bank: it generates the J/K inputs instead of consuming them.
- Steps an external WIDTH-bit bank of JK flops from its present value up to a requested target, one increment per step.
- Derives J/K per bit from the JK excitation table and checks the fed-back state after every step.
- Used wherever a counter or register in the design is built from discrete JK flops and must be driven to a value.

Parameters:
WIDTH, 4, bit width of the driven JK bank, target and feedback

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when ready=1
target  input  WIDTH  destination value; sampled when start is accepted
q_fb  input  WIDTH  present state (Q) of the external JK bank
ready  output  1  1 in IDLE only
j  output  WIDTH  registered J drive to the JK bank
k  output  WIDTH  registered K drive to the JK bank
busy  output  1  1 in DRIVE and CHECK
done  output  1  one-cycle pulse on successful completion
err  output  1  sticky feedback-mismatch flag
expected  output  WIDTH  value the bank must hold after the current step

Behaviour:
- Interface (already decided): one clock, `clock`; `reset` is synchronous and active-high.
- Reset values: state=IDLE, j=0, k=0, ready=1, busy=0, done=0, err=0, expected=0, target register=0.
- Reset mid-operation: same values on the next edge, regardless of state; any step in flight is abandoned.
- Outputs j, k, done, err and expected are all registered.
- j=k=0 (hold) in every state except DRIVE.
- FSM states: IDLE, DRIVE, CHECK, DONE, ERR.
- IDLE:
  - start=1 latches target.
  - If q_fb==target: go to DONE; no step is issued.
  - Otherwise: expected <= q_fb+1 (mod 2^WIDTH, so all-ones wraps to 0), then go to DRIVE.
- DRIVE (1 cycle): j/k hold the per-bit excitation for q_fb -> expected:
  - 0->0: j=0, k=0
  - 0->1: j=1, k=0
  - 1->0: j=0, k=1
  - 1->1: j=0, k=0
  - The excitation is computed from q_fb and expected on the edge that enters DRIVE.
  - The external bank captures j/k on the edge that ends DRIVE.
  - Next state is CHECK.
- CHECK (1 cycle, j=k=0):
  - q_fb != expected: go to ERR.
  - q_fb == expected and expected == target: go to DONE.
  - Otherwise: expected <= expected+1 (mod 2^WIDTH), then go to DRIVE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- ERR:
  - err=1, ready=0, j=k=0.
  - expected holds the failing value.
  - Only reset exits ERR; start is ignored.
- start while not IDLE is ignored; target is not re-sampled.
- Latency: for S increments (S = (target - q_fb) mod 2^WIDTH, 0..2^WIDTH-1), done is high in cycle 2S+1 after the accepting edge. S=0 gives done the cycle after acceptance.
- Target below the present value is reached by wrap-around; there is no decrement.

Optional Feature:
- Macro: JK_TOGGLE_EN.
- Defined: every bit that changes (0->1 or 1->0) is driven with j=1, k=1 (toggle). Unchanged bits stay j=0, k=0.
- Undefined: the set/reset encoding above is used, and j=k=1 is never emitted.
- Sequencing, latency and the checking rules are identical in both builds.

Test Plan:
- Bench setup: a behavioural JK bank model (WIDTH=4) closes the q_fb loop.
- Bank=3, start with target=6 -> 3 DRIVE/CHECK pairs with expected 4, 5, 6. First j=4'b0100, k=4'b0011. done pulse in cycle 7 after acceptance; err=0; bank=6.
- Bank=5, target=5 -> no j/k activity; done pulse in cycle 1; ready returns to 1 the cycle after.
- Bank=14, target=1 -> steps to 15, 0, 1 (wrap). At the 15->0 step, k=4'b1111, j=0. done in cycle 7.
- Bank model forces bit0 stuck at 0, bank=0, target=2 -> first CHECK fails; err=1 with expected=1; state stays in ERR with ready=0 and start ignored. reset=1 for one edge clears err and returns ready=1.
- Mid-run: bank=0, target=9; assert reset during the third DRIVE -> next cycle j=k=0, busy=0, ready=1, no done. A new start with target=9 from the bank's current value completes normally.
- JK_TOGGLE_EN build, bank=3, target=4 -> single DRIVE with j=k=4'b0111; done in cycle 3; bank=4.
